framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/framebuffer_writer.sv | 254 +++++++++++++++++++++++++
 tb/tb_framebuffer_writer.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: streams 16-bit pixel beats through a FIFO into SDRAM
// as fixed-length write bursts, with a small CSR block for base/enable/status.
//
// Parameters: BURSTLENGTH (words per burst), FIFO_DEPTH (>= 2*BURSTLENGTH),
//             FRAME_WORDS (words per frame, multiple of BURSTLENGTH).
// Ports:
//   clk, rst                  single clock, asynchronous active-high reset
//   m0_*                      SDRAM write master (byte address, stall input)
//   s0_*                      CSR slave: 0 base A, 1 base B, 2 enable, 3 status
//   as0_*                     pixel stream sink (valid/ready, sop marks frame start)
// Build option: define FBW_DOUBLE_BUFFER_EN to add base B and ping-pong
// between base A and base B at every frame boundary.
module framebuffer_writer #(
    parameter int BURSTLENGTH = 32,
    parameter int FIFO_DEPTH  = 64,
    parameter int FRAME_WORDS = 76800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_waitrequest,
    output logic [25:0] m0_address,
    output logic        m0_write_n,
    output logic        m0_read_n,
    output logic [15:0] m0_writedata,
    output logic        m0_chipselect,
    output logic [1:0]  m0_byteenable_n,
    input  logic [1:0]  s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [31:0] s0_writedata,
    output logic [31:0] s0_readdata,
    input  logic        as0_valid,
    output logic        as0_ready,
    input  logic [15:0] as0_data,
    input  logic        as0_sop
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(BURSTLENGTH + 1);
    localparam int IW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [25:0] BURST_BYTES = 26'(2 * BURSTLENGTH);
    localparam logic [25:0] FRAME_BYTES = 26'(2 * FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, WRITE, WRITE_DONE} state_t;

    state_t          state_q, state_d;
    logic [25:0]     base_a_q, base_a_d;
`ifdef FBW_DOUBLE_BUFFER_EN
    logic [25:0]     base_b_q, base_b_d;
`endif
    logic            enable_q, enable_d;
    logic            sop_err_q, sop_err_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            act_buf_q, act_buf_d;
    logic [25:0]     frame_base_q, frame_base_d;
    logic [25:0]     offset_q, offset_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [IW-1:0]   in_cnt_q, in_cnt_d;
    logic            synced_q, synced_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [15:0]     mem_q [FIFO_DEPTH];

    logic            fifo_full, accept, push, pop, flush, en_rise;
    logic [25:0]     off_nxt;
    logic            unused_wdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_wdata = ^s0_writedata[31:26];

    assign fifo_full = (fifo_cnt_q == CW'(FIFO_DEPTH));
    // Before sync every beat is taken so stale non-sop words drain away.
    assign as0_ready = enable_q && (!synced_q || !fifo_full);
    assign accept    = as0_valid && as0_ready;
    assign push      = accept && (synced_q || as0_sop);
    assign pop       = (state_q == WRITE) && !m0_waitrequest;
    // Disable only takes hold once any running burst has drained.
    assign flush     = !enable_q && (state_q == IDLE);
    assign en_rise   = s0_write && (s0_address == 2'd2)
                       && s0_writedata[0] && !enable_q;
    assign off_nxt   = offset_q + BURST_BYTES;

    assign m0_read_n       = 1'b1;
    assign m0_byteenable_n = 2'b00;
    assign m0_chipselect   = !m0_write_n;
    assign m0_writedata    = mem_q[rd_ptr_q];
    assign m0_address      = frame_base_q + offset_q
                             + (26'(burst_cnt_q) << 1);

    always_comb begin
        state_d      = state_q;
        base_a_d     = base_a_q;
`ifdef FBW_DOUBLE_BUFFER_EN
        base_b_d     = base_b_q;
`endif
        enable_d     = enable_q;
        sop_err_d    = sop_err_q;
        frame_cnt_d  = frame_cnt_q;
        act_buf_d    = act_buf_q;
        frame_base_d = frame_base_q;
        offset_d     = offset_q;
        burst_cnt_d  = burst_cnt_q;
        in_cnt_d     = in_cnt_q;
        synced_d     = synced_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        m0_write_n   = 1'b1;

        if (s0_write) begin
            case (s0_address)
                2'd0: base_a_d = s0_writedata[25:0];
`ifdef FBW_DOUBLE_BUFFER_EN
                2'd1: base_b_d = s0_writedata[25:0];
`endif
                2'd2: enable_d = s0_writedata[0];
                2'd3: sop_err_d = 1'b0;
                default: ;
            endcase
        end
        if (en_rise) begin
            frame_base_d = base_a_q;
            act_buf_d    = 1'b0;
        end

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
            in_cnt_d = (in_cnt_q == IW'(FRAME_WORDS - 1)) ? '0
                                                          : in_cnt_q + 1'b1;
            // A stray sop mid-frame is kept as data; only flagged.
            if (synced_q && as0_sop && in_cnt_q != '0)
                sop_err_d = 1'b1;
            if (!synced_q)
                synced_d = 1'b1;
        end
        if (pop)
            rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (enable_q && fifo_cnt_q >= CW'(BURSTLENGTH))
                    state_d = WRITE;
            end
            WRITE: begin
                m0_write_n = 1'b0;
                if (!m0_waitrequest) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == BW'(BURSTLENGTH - 1))
                        state_d = WRITE_DONE;
                end
            end
            WRITE_DONE: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
                if (off_nxt == FRAME_BYTES) begin
                    offset_d    = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
`ifdef FBW_DOUBLE_BUFFER_EN
                    act_buf_d    = !act_buf_q;
                    frame_base_d = act_buf_q ? base_a_q : base_b_q;
`else
                    frame_base_d = base_a_q;
`endif
                end else begin
                    offset_d = off_nxt;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            fifo_cnt_d  = '0;
            synced_d    = 1'b0;
            offset_d    = '0;
            in_cnt_d    = '0;
            burst_cnt_d = '0;
        end
    end

    always_comb begin
        s0_readdata = '0;
        if (s0_read && !rst) begin
            case (s0_address)
                2'd0: s0_readdata = {6'd0, base_a_q};
`ifdef FBW_DOUBLE_BUFFER_EN
                2'd1: s0_readdata = {6'd0, base_b_q};
`else
                2'd1: s0_readdata = '0;
`endif
                2'd2: s0_readdata = {31'd0, enable_q};
                default: s0_readdata = {frame_cnt_q, 12'd0, sop_err_q,
                                        act_buf_q, (state_q != IDLE),
                                        enable_q};
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_a_q     <= '0;
`ifdef FBW_DOUBLE_BUFFER_EN
            base_b_q     <= '0;
`endif
            enable_q     <= 1'b0;
            sop_err_q    <= 1'b0;
            frame_cnt_q  <= '0;
            act_buf_q    <= 1'b0;
            frame_base_q <= '0;
            offset_q     <= '0;
            burst_cnt_q  <= '0;
            in_cnt_q     <= '0;
            synced_q     <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            base_a_q     <= base_a_d;
`ifdef FBW_DOUBLE_BUFFER_EN
            base_b_q     <= base_b_d;
`endif
            enable_q     <= enable_d;
            sop_err_q    <= sop_err_d;
            frame_cnt_q  <= frame_cnt_d;
            act_buf_q    <= act_buf_d;
            frame_base_q <= frame_base_d;
            offset_q     <= offset_d;
            burst_cnt_q  <= burst_cnt_d;
            in_cnt_q     <= in_cnt_d;
            synced_q     <= synced_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= as0_data;
    end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed self-checking bench for framebuffer_writer
// (small frame of 64 words so frame boundaries are reachable).
module tb_framebuffer_writer;
    localparam int BL = 32;
    localparam int FW = 64;
`ifdef FBW_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam logic [31:0] BUFBIT = DB ? 32'h4 : 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_waitrequest = 1'b0;
    logic [25:0] m0_address;
    logic        m0_write_n;
    logic        m0_read_n;
    logic [15:0] m0_writedata;
    logic        m0_chipselect;
    logic [1:0]  m0_byteenable_n;
    logic [1:0]  s0_address;
    logic        s0_read;
    logic        s0_write;
    logic [31:0] s0_writedata;
    logic [31:0] s0_readdata;
    logic        as0_valid;
    logic        as0_ready;
    logic [15:0] as0_data;
    logic        as0_sop;

    int n_cmp = 0;
    int n_bad = 0;
    int wait_mode = 0;
    int hold_err = 0;
    logic        hold_pend = 1'b0;
    logic [25:0] hold_a;
    logic [15:0] hold_d;
    logic [25:0] aq[$];
    logic [15:0] dq[$];

    framebuffer_writer #(
        .BURSTLENGTH(BL),
        .FIFO_DEPTH (64),
        .FRAME_WORDS(FW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_waitrequest (m0_waitrequest),
        .m0_address     (m0_address),
        .m0_write_n     (m0_write_n),
        .m0_read_n      (m0_read_n),
        .m0_writedata   (m0_writedata),
        .m0_chipselect  (m0_chipselect),
        .m0_byteenable_n(m0_byteenable_n),
        .s0_address     (s0_address),
        .s0_read        (s0_read),
        .s0_write       (s0_write),
        .s0_writedata   (s0_writedata),
        .s0_readdata    (s0_readdata),
        .as0_valid      (as0_valid),
        .as0_ready      (as0_ready),
        .as0_data       (as0_data),
        .as0_sop        (as0_sop)
    );

    always #5 clk = ~clk;

    // Stall generator: 0 never, 1 every other cycle, 2 always.
    always @(posedge clk) begin
        #1;
        case (wait_mode)
            0:       m0_waitrequest = 1'b0;
            1:       m0_waitrequest = !m0_waitrequest;
            default: m0_waitrequest = 1'b1;
        endcase
    end

    // SDRAM model: log accepted writes, flag words changing under a stall.
    always @(negedge clk) begin
        if (!m0_write_n) begin
            if (hold_pend && (m0_address != hold_a || m0_writedata != hold_d))
                hold_err++;
            if (!m0_waitrequest) begin
                aq.push_back(m0_address);
                dq.push_back(m0_writedata);
            end
            hold_pend = m0_waitrequest;
            hold_a = m0_address;
            hold_d = m0_writedata;
        end else begin
            if (hold_pend && !rst)
                hold_err++;
            hold_pend = 1'b0;
        end
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        s0_address = a;
        s0_writedata = d;
        s0_write = 1'b1;
        @(posedge clk); #1;
        s0_write = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        s0_address = a;
        s0_read = 1'b1;
        #2;
        d = s0_readdata;
        @(posedge clk); #1;
        s0_read = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic sop);
        int n;
        as0_valid = 1'b1;
        as0_data = d;
        as0_sop = sop;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!as0_ready && n < 2000);
        if (!as0_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL beat_timeout: as0_ready=%b required 1", as0_ready);
        end
        @(posedge clk); #1;
        as0_valid = 1'b0;
        as0_sop = 1'b0;
    endtask

    task automatic wait_writes(input int want, input int budget);
        int n;
        n = 0;
        while (aq.size() < want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (aq.size() < want) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout: got %0d writes required %0d",
                     aq.size(), want);
        end
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        s0_read = 1'b1;
        s0_address = 2'd3;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (m0_write_n !== 1'b1) begin
            n_bad++; $display("FAIL rst_write_n: got %b required 1", m0_write_n);
        end
        n_cmp++;
        if (m0_read_n !== 1'b1) begin
            n_bad++; $display("FAIL rst_read_n: got %b required 1", m0_read_n);
        end
        n_cmp++;
        if (m0_chipselect !== 1'b0) begin
            n_bad++; $display("FAIL rst_cs: got %b required 0", m0_chipselect);
        end
        n_cmp++;
        if (m0_address !== 26'h0) begin
            n_bad++; $display("FAIL rst_addr: got %h required 0", m0_address);
        end
        n_cmp++;
        if (as0_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_ready: got %b required 0", as0_ready);
        end
        n_cmp++;
        if (s0_readdata !== 32'h0) begin
            n_bad++; $display("FAIL rst_readdata: got %h required 0", s0_readdata);
        end
        n_cmp++;
        if (m0_byteenable_n !== 2'b00) begin
            n_bad++; $display("FAIL rst_be: got %b required 00", m0_byteenable_n);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s0_read = 1'b0;
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++; $display("FAIL post_rst_status: got %h required 0", rd);
        end
    endtask

    task automatic test_single_burst();
        logic [31:0] rd;
        aq.delete(); dq.delete();
        csr_write(2'd0, 32'h0010_0000);
        csr_write(2'd2, 32'h1);
        for (int i = 0; i < BL; i++)
            send_beat(16'(16'h1000 + i), i == 0);
        wait_writes(BL, 500);
        n_cmp++;
        if (aq.size() != BL) begin
            n_bad++; $display("FAIL single_count: got %0d required %0d", aq.size(), BL);
        end
        for (int i = 0; i < BL; i++) begin
            if (i < aq.size()) begin
                n_cmp++;
                if (aq[i] !== 26'(32'h10_0000 + 2 * i)) begin
                    n_bad++;
                    $display("FAIL single_addr[%0d]: got %h required %h",
                             i, aq[i], 26'(32'h10_0000 + 2 * i));
                end
                n_cmp++;
                if (dq[i] !== 16'(16'h1000 + i)) begin
                    n_bad++;
                    $display("FAIL single_data[%0d]: got %h required %h",
                             i, dq[i], 16'(16'h1000 + i));
                end
            end
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0000_0001) begin
            n_bad++; $display("FAIL single_status: got %h required 00000001", rd);
        end
    endtask

    task automatic test_waitrequest();
        logic [31:0] rd;
        aq.delete(); dq.delete();
        hold_err = 0;
        wait_mode = 1;
        for (int i = 0; i < BL; i++)
            send_beat(16'(16'h2000 + i), 1'b0);
        wait_writes(BL, 1000);
        wait_mode = 0;
        n_cmp++;
        if (aq.size() != BL) begin
            n_bad++; $display("FAIL wait_count: got %0d required %0d", aq.size(), BL);
        end
        n_cmp++;
        if (hold_err != 0) begin
            n_bad++; $display("FAIL wait_hold: got %0d changes required 0", hold_err);
        end
        for (int i = 0; i < BL; i++) begin
            if (i < aq.size()) begin
                n_cmp++;
                if (aq[i] !== 26'(32'h10_0040 + 2 * i) || dq[i] !== 16'(16'h2000 + i)) begin
                    n_bad++;
                    $display("FAIL wait_word[%0d]: got %h/%h required %h/%h",
                             i, aq[i], dq[i], 26'(32'h10_0040 + 2 * i),
                             16'(16'h2000 + i));
                end
            end
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== (32'h0001_0001 | BUFBIT)) begin
            n_bad++;
            $display("FAIL wait_status: got %h required %h", rd, 32'h0001_0001 | BUFBIT);
        end
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        logic [25:0] base;
        int n;
        base = DB ? 26'h0 : 26'h10_0000;
        aq.delete(); dq.delete();
        wait_mode = 2;
        for (int i = 0; i < 40; i++)
            send_beat(16'(16'h3000 + i), i == 0);
        wait_mode = 0;
        n = 0;
        while (aq.size() < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        csr_write(2'd2, 32'h0);
        repeat (100) @(posedge clk);
        #1;
        n_cmp++;
        if (aq.size() != BL) begin
            n_bad++; $display("FAIL dis_count: got %0d required %0d", aq.size(), BL);
        end
        for (int i = 0; i < BL; i++) begin
            if (i < aq.size()) begin
                n_cmp++;
                if (aq[i] !== 26'(base + 26'(2 * i)) || dq[i] !== 16'(16'h3000 + i)) begin
                    n_bad++;
                    $display("FAIL dis_word[%0d]: got %h/%h required %h/%h",
                             i, aq[i], dq[i], 26'(base + 26'(2 * i)),
                             16'(16'h3000 + i));
                end
            end
        end
        n_cmp++;
        if (as0_ready !== 1'b0) begin
            n_bad++; $display("FAIL dis_ready: got %b required 0", as0_ready);
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== (32'h0001_0000 | BUFBIT)) begin
            n_bad++;
            $display("FAIL dis_status: got %h required %h", rd, 32'h0001_0000 | BUFBIT);
        end
    endtask

    task automatic test_sync();
        logic [31:0] rd;
        aq.delete(); dq.delete();
        csr_write(2'd0, 32'h0020_0000);
        csr_write(2'd2, 32'h1);
        for (int i = 0; i < 5; i++)
            send_beat(16'(16'hBAD0 + i), 1'b0);
        for (int i = 0; i < BL; i++)
            send_beat(16'(16'h5000 + i), i == 0);
        wait_writes(BL, 500);
        n_cmp++;
        if (aq.size() != BL) begin
            n_bad++; $display("FAIL sync_count: got %0d required %0d", aq.size(), BL);
        end
        for (int i = 0; i < BL; i++) begin
            if (i < aq.size()) begin
                n_cmp++;
                if (aq[i] !== 26'(32'h20_0000 + 2 * i) || dq[i] !== 16'(16'h5000 + i)) begin
                    n_bad++;
                    $display("FAIL sync_word[%0d]: got %h/%h required %h/%h",
                             i, aq[i], dq[i], 26'(32'h20_0000 + 2 * i),
                             16'(16'h5000 + i));
                end
            end
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0001_0001) begin
            n_bad++; $display("FAIL sync_status: got %h required 00010001", rd);
        end
    endtask

    task automatic test_sop_error();
        logic [31:0] rd;
        aq.delete(); dq.delete();
        for (int i = 0; i < BL; i++)
            send_beat(16'(16'h6000 + i), i == 10);
        wait_writes(BL, 500);
        n_cmp++;
        if (aq.size() != BL) begin
            n_bad++; $display("FAIL sop_count: got %0d required %0d", aq.size(), BL);
        end
        for (int i = 0; i < BL; i++) begin
            if (i < aq.size()) begin
                n_cmp++;
                if (aq[i] !== 26'(32'h20_0040 + 2 * i) || dq[i] !== 16'(16'h6000 + i)) begin
                    n_bad++;
                    $display("FAIL sop_word[%0d]: got %h/%h required %h/%h",
                             i, aq[i], dq[i], 26'(32'h20_0040 + 2 * i),
                             16'(16'h6000 + i));
                end
            end
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== (32'h0002_0009 | BUFBIT)) begin
            n_bad++;
            $display("FAIL sop_err_set: got %h required %h", rd, 32'h0002_0009 | BUFBIT);
        end
        csr_write(2'd3, 32'h0);
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== (32'h0002_0001 | BUFBIT)) begin
            n_bad++;
            $display("FAIL sop_err_clr: got %h required %h", rd, 32'h0002_0001 | BUFBIT);
        end
    endtask

    task automatic test_double_frame();
        logic [31:0] rd;
        logic [25:0] exp_a;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        aq.delete(); dq.delete();
        csr_write(2'd0, 32'h0);
        csr_write(2'd1, 32'h8000);
        csr_write(2'd2, 32'h1);
        csr_read(2'd1, rd);
        n_cmp++;
        if (rd !== (DB ? 32'h8000 : 32'h0)) begin
            n_bad++;
            $display("FAIL base_b_read: got %h required %h", rd, DB ? 32'h8000 : 32'h0);
        end
        for (int i = 0; i < 2 * FW; i++)
            send_beat(16'(16'h7000 + i), (i % FW) == 0);
        wait_writes(2 * FW, 2000);
        n_cmp++;
        if (aq.size() != 2 * FW) begin
            n_bad++; $display("FAIL dbl_count: got %0d required %0d", aq.size(), 2 * FW);
        end
        for (int i = 0; i < 2 * FW; i++) begin
            if (i < aq.size()) begin
                if (i < FW)
                    exp_a = 26'(2 * i);
                else
                    exp_a = 26'((DB ? 32'h8000 : 32'h0) + 2 * (i - FW));
                n_cmp++;
                if (aq[i] !== exp_a || dq[i] !== 16'(16'h7000 + i)) begin
                    n_bad++;
                    $display("FAIL dbl_word[%0d]: got %h/%h required %h/%h",
                             i, aq[i], dq[i], exp_a, 16'(16'h7000 + i));
                end
            end
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0002_0001) begin
            n_bad++; $display("FAIL dbl_status: got %h required 00020001", rd);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] rd;
        int n;
        int seen;
        aq.delete(); dq.delete();
        wait_mode = 2;
        for (int i = 0; i < BL; i++)
            send_beat(16'(16'h9000 + i), i == 0);
        wait_mode = 0;
        n = 0;
        while (aq.size() < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m0_write_n !== 1'b1 || m0_chipselect !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_strobe: got wn=%b cs=%b required 1/0",
                     m0_write_n, m0_chipselect);
        end
        n_cmp++;
        if (m0_address !== 26'h0 || as0_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_addr: got %h rdy=%b required 0/0", m0_address, as0_ready);
        end
        seen = aq.size();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        n_cmp++;
        if (aq.size() != seen) begin
            n_bad++;
            $display("FAIL midrst_abort: got %0d writes required %0d", aq.size(), seen);
        end
        csr_read(2'd3, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++; $display("FAIL midrst_status: got %h required 0", rd);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s0_address = 2'd0;
        s0_read = 1'b0;
        s0_write = 1'b0;
        s0_writedata = 32'h0;
        as0_valid = 1'b0;
        as0_data = 16'h0;
        as0_sop = 1'b0;
        test_reset();
        test_single_burst();
        test_waitrequest();
        test_disable();
        test_sync();
        test_sop_error();
        test_double_frame();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
